// File: rtl/core_dmem_port.sv
// Per-core data-memory initiator: accepts one load/store at a time from the
// execute stage, drives one-cycle memory strobes, and returns a response.
module core_dmem_port #(
  parameter int unsigned TAM     = 16,
  parameter int unsigned Lmem    = 8,
  parameter int unsigned CORE_ID = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_write,
  input  logic [TAM-1:0] req_addr,
  input  logic [TAM-1:0] req_wdata,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [TAM-1:0] rsp_rdata,
  output logic           rsp_err,
  input  logic           peer_shared_wr,
  output logic [TAM-1:0] dataADDR,
  output logic [TAM-1:0] dataIN,
  output logic           dataLoad,
  output logic           dataWrite,
  input  logic [TAM-1:0] dataOUT
);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, RESP} state_t;

  state_t state;

  // Any address bit above the shared-select bit lies outside both windows.
  logic addr_err_c;
  assign addr_err_c = |req_addr[TAM-1:Lmem+1];

  // The strobe registers carry the latched request during ISSUE, so a
  // core-1 shared store colliding with the peer's shared store is detected
  // directly from them; the memory defers that write by one cycle.
  logic hold_c;
  assign hold_c = (CORE_ID == 32'd1) && dataWrite && dataADDR[Lmem] && peer_shared_wr;

  // Request/strobe/response sequencing with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= TAM'(0);
      dataADDR  <= TAM'(0);
      dataIN    <= TAM'(0);
      dataLoad  <= 1'b0;
      dataWrite <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            if (addr_err_c) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              state     <= RESP;
            end else begin
              dataLoad  <= ~req_write;
              dataWrite <= req_write;
              dataADDR  <= req_addr;
              dataIN    <= req_write ? req_wdata : TAM'(0);
              state     <= ISSUE;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        ISSUE: begin
          dataLoad  <= 1'b0;
          dataWrite <= 1'b0;
          dataADDR  <= TAM'(0);
          dataIN    <= TAM'(0);
          if (dataLoad) begin
            rsp_rdata <= dataOUT;
          end
          if (hold_c) begin
            state <= HOLD;
          end else begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            state     <= RESP;
          end
        end
        HOLD: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_dmem_port.sv
// Directed bench for core_dmem_port: a CORE_ID=1 port against a small
// memory model, plus a CORE_ID=0 port for the no-hold case.
module tb_core_dmem_port;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // CORE_ID=1 port signals
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_addr  = 16'h0;
  logic [15:0] req_wdata = 16'h0;
  logic        rsp_ready = 1'b0;
  logic        peer      = 1'b0;
  logic        req_ready, rsp_valid, rsp_err, dataLoad, dataWrite;
  logic [15:0] rsp_rdata, dataADDR, dataIN;
  logic [15:0] dataOUT = 16'h0;

  // CORE_ID=0 port signals
  logic        req_valid0 = 1'b0;
  logic        req_write0 = 1'b0;
  logic [15:0] req_addr0  = 16'h0;
  logic [15:0] req_wdata0 = 16'h0;
  logic        rsp_ready0 = 1'b0;
  logic        peer0      = 1'b0;
  logic        req_ready0, rsp_valid0, rsp_err0, dataLoad0, dataWrite0;
  logic [15:0] rsp_rdata0, dataADDR0, dataIN0;
  logic [15:0] dataOUT0 = 16'h0;

  core_dmem_port #(.TAM(16), .Lmem(8), .CORE_ID(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .peer_shared_wr(peer),
    .dataADDR(dataADDR), .dataIN(dataIN), .dataLoad(dataLoad),
    .dataWrite(dataWrite), .dataOUT(dataOUT)
  );

  core_dmem_port #(.TAM(16), .Lmem(8), .CORE_ID(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
    .req_addr(req_addr0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0),
    .rsp_err(rsp_err0), .peer_shared_wr(peer0),
    .dataADDR(dataADDR0), .dataIN(dataIN0), .dataLoad(dataLoad0),
    .dataWrite(dataWrite0), .dataOUT(dataOUT0)
  );

  // Memory model acting in the clk-low phase (self + shared = 512 words)
  logic [15:0] mem [0:511] = '{default: 16'h0};
  always @(negedge clk) begin
    if (dataWrite) mem[dataADDR[8:0]] <= dataIN;
    if (dataLoad)  dataOUT <= mem[dataADDR[8:0]];
  end

  int compared   = 0;
  int mismatched = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge (port must be ready); returns just after acceptance.
  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 16'h0;
    req_wdata = 16'h0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk1("rst_req_ready", req_ready, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_dataLoad", dataLoad, 1'b0);
    chk1("rst_dataWrite", dataWrite, 1'b0);
    chk16("rst_dataADDR", dataADDR, 16'h0);
    chk16("rst_rsp_rdata", rsp_rdata, 16'h0);
    rst = 1'b0;
    tick();
    chk1("rel_req_ready", req_ready, 1'b1);

    // Self-region store
    issue(1'b1, 16'h0012, 16'hBEEF);
    chk1("st_dataWrite", dataWrite, 1'b1);
    chk1("st_dataLoad", dataLoad, 1'b0);
    chk16("st_dataADDR", dataADDR, 16'h0012);
    chk16("st_dataIN", dataIN, 16'hBEEF);
    chk1("st_rsp_valid_early", rsp_valid, 1'b0);
    chk1("st_req_ready", req_ready, 1'b0);
    tick();
    chk1("st_dataWrite_off", dataWrite, 1'b0);
    chk16("st_dataADDR_off", dataADDR, 16'h0);
    chk16("st_dataIN_off", dataIN, 16'h0);
    chk1("st_rsp_valid", rsp_valid, 1'b1);
    chk1("st_rsp_err", rsp_err, 1'b0);
    consume();
    chk1("st_rsp_done", rsp_valid, 1'b0);
    chk1("st_req_ready_back", req_ready, 1'b1);

    // Self-region load of the stored word
    issue(1'b0, 16'h0012, 16'h0);
    chk1("ld_dataLoad", dataLoad, 1'b1);
    chk1("ld_dataWrite", dataWrite, 1'b0);
    chk16("ld_dataADDR", dataADDR, 16'h0012);
    chk16("ld_dataIN", dataIN, 16'h0);
    chk1("ld_rsp_valid_early", rsp_valid, 1'b0);
    tick();
    chk1("ld_rsp_valid", rsp_valid, 1'b1);
    chk16("ld_rsp_rdata", rsp_rdata, 16'hBEEF);
    chk1("ld_rsp_err", rsp_err, 1'b0);
    chk1("ld_dataLoad_off", dataLoad, 1'b0);
    consume();

    // Shared-region word 0x0105 = 0x1234, then load it
    issue(1'b1, 16'h0105, 16'h1234);
    tick();
    consume();
    issue(1'b0, 16'h0105, 16'h0);
    chk1("sh_dataLoad", dataLoad, 1'b1);
    chk16("sh_dataADDR", dataADDR, 16'h0105);
    tick();
    chk1("sh_rsp_valid", rsp_valid, 1'b1);
    chk16("sh_rsp_rdata", rsp_rdata, 16'h1234);

    // Backpressure: response held, a waiting request is not accepted
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h0012;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("bp_rsp_valid", rsp_valid, 1'b1);
      chk16("bp_rsp_rdata", rsp_rdata, 16'h1234);
      chk1("bp_req_ready", req_ready, 1'b0);
      chk1("bp_dataLoad", dataLoad, 1'b0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk1("bp_rsp_released", rsp_valid, 1'b0);
    chk1("bp_req_ready_back", req_ready, 1'b1);
    chk1("bp_not_yet_accepted", dataLoad, 1'b0);
    tick();
    req_valid = 1'b0;
    req_addr  = 16'h0;
    chk1("bp_accept_dataLoad", dataLoad, 1'b1);
    chk16("bp_accept_dataADDR", dataADDR, 16'h0012);
    chk1("bp_accept_req_ready", req_ready, 1'b0);
    tick();
    chk1("bp2_rsp_valid", rsp_valid, 1'b1);
    chk16("bp2_rsp_rdata", rsp_rdata, 16'hBEEF);
    consume();

    // Range error: no strobe, one-cycle error response, rdata unchanged
    issue(1'b0, 16'h0200, 16'h0);
    chk1("err_rsp_valid", rsp_valid, 1'b1);
    chk1("err_rsp_err", rsp_err, 1'b1);
    chk1("err_dataLoad", dataLoad, 1'b0);
    chk1("err_dataWrite", dataWrite, 1'b0);
    chk16("err_rsp_rdata", rsp_rdata, 16'hBEEF);
    chk1("err_req_ready", req_ready, 1'b0);
    consume();
    chk1("err_rsp_err_clr", rsp_err, 1'b0);
    chk1("err_req_ready_back", req_ready, 1'b1);

    // Collision hold: core-1 shared store while peer writes shared
    peer = 1'b1;
    issue(1'b1, 16'h0140, 16'h5555);
    chk1("col_dataWrite", dataWrite, 1'b1);
    chk16("col_dataADDR", dataADDR, 16'h0140);
    tick();
    peer = 1'b0;
    chk1("col_hold_rsp_valid", rsp_valid, 1'b0);
    chk1("col_hold_dataWrite", dataWrite, 1'b0);
    chk1("col_hold_req_ready", req_ready, 1'b0);
    tick();
    chk1("col_rsp_valid", rsp_valid, 1'b1);
    chk1("col_rsp_err", rsp_err, 1'b0);
    consume();

    // Same store without peer activity: normal latency
    issue(1'b1, 16'h0140, 16'h6666);
    tick();
    chk1("nocol_rsp_valid", rsp_valid, 1'b1);
    consume();

    // Self store and shared load never hold, even with peer active
    peer = 1'b1;
    issue(1'b1, 16'h0040, 16'h7777);
    tick();
    chk1("self_st_nohold", rsp_valid, 1'b1);
    consume();
    issue(1'b0, 16'h0140, 16'h0);
    tick();
    chk1("sh_ld_nohold", rsp_valid, 1'b1);
    chk16("sh_ld_rdata", rsp_rdata, 16'h6666);
    consume();
    peer = 1'b0;

    // Core 0 never holds on a colliding shared store
    peer0      = 1'b1;
    req_valid0 = 1'b1;
    req_write0 = 1'b1;
    req_addr0  = 16'h0140;
    req_wdata0 = 16'h1111;
    tick();
    req_valid0 = 1'b0;
    chk1("c0_dataWrite", dataWrite0, 1'b1);
    chk16("c0_dataIN", dataIN0, 16'h1111);
    tick();
    chk1("c0_nohold_rsp_valid", rsp_valid0, 1'b1);
    rsp_ready0 = 1'b1;
    tick();
    rsp_ready0 = 1'b0;
    peer0      = 1'b0;
    chk1("c0_rsp_done", rsp_valid0, 1'b0);

    // Reset during ISSUE of a store
    issue(1'b1, 16'h0033, 16'h5A5A);
    tick();
    consume();
    issue(1'b1, 16'h0033, 16'hAAAA);
    chk1("rm_dataWrite_pre", dataWrite, 1'b1);
    rst = 1'b1;
    #1;
    chk1("rm_dataWrite", dataWrite, 1'b0);
    chk16("rm_dataADDR", dataADDR, 16'h0);
    chk16("rm_dataIN", dataIN, 16'h0);
    chk1("rm_req_ready", req_ready, 1'b0);
    chk1("rm_rsp_valid", rsp_valid, 1'b0);
    chk1("rm_rsp_err", rsp_err, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk1("rm_req_ready_back", req_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk1("rm_no_rsp", rsp_valid, 1'b0);
      tick();
    end
    issue(1'b0, 16'h0033, 16'h0);
    tick();
    chk1("rm_ld_rsp_valid", rsp_valid, 1'b1);
    chk16("rm_aborted_store", rsp_rdata, 16'h5A5A);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
